// File: rtl/demapper_qam16.sv
//------------------------------------------------------------------------------
// Module      : demapper_qam16
// Description : 16-QAM hard-decision demapper. Slices a signed I/Q symbol into
//               a 4-bit Gray nibble {sI, mI, sQ, mQ}, buffers it in a one-entry
//               hold register and serialises it MSB-first on data_out.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demapper_qam16 #(
  parameter int width_data = 16,
  parameter int thr        = 8192,
  parameter int wid_cnt    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [width_data-1:0] data_I,
  input  logic [width_data-1:0] data_Q,
  input  logic                  clr_ovf,
  output logic                  ready,
  output logic                  data_out,
  output logic                  valid_out,
  output logic                  last_bit,
  output logic                  overflow,
  output logic [wid_cnt-1:0]    sym_count
);

  // Decision thresholds as signed constants of the sample width
  localparam logic signed [width_data-1:0] c_THR_P = width_data'(thr);
  localparam logic signed [width_data-1:0] c_THR_N = width_data'(-thr);
  localparam logic signed [width_data-1:0] c_ZERO  = '0;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [1:0]   r_cnt;
  logic [1:0]   w_cnt_nxt;
  logic [3:0]   r_shift;
  logic [3:0]   w_shift_nxt;
  logic [3:0]   r_hold;
  logic         r_hold_full;
  logic         r_overflow;
  logic [wid_cnt-1:0] r_sym_count;

  logic         w_drain;
  logic         w_ready;
  logic         w_accept;
  logic         w_drop;
  logic [1:0]   w_bits_I;
  logic [1:0]   w_bits_Q;

  // Pure signed compares; the most negative code falls out as outer/negative
  function automatic logic [1:0] f_slice(input logic [width_data-1:0] x);
    logic signed [width_data-1:0] v;
    v = $signed(x);
    f_slice[1] = (v >= c_ZERO);
    f_slice[0] = (v > c_THR_N) && (v < c_THR_P);
  endfunction

  // Slice both rails and derive the hold-register handshake
  always_comb begin
    w_bits_I = f_slice(data_I);
    w_bits_Q = f_slice(data_Q);
    // The shifter takes the held symbol at the next edge in these states
    w_drain  = (r_state == S_IDLE) || ((r_state == S_SHIFT) && (r_cnt == 2'd3));
    w_ready  = !r_hold_full || w_drain;
    w_accept = start && w_ready;
    w_drop   = start && !w_ready;
  end

  // Shifter FSM: next state, bit counter and shift register load
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    case (r_state)
      S_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = r_hold;
          w_cnt_nxt   = 2'd0;
        end
      end
      S_SHIFT: begin
        if (r_cnt == 2'd3) begin
          w_cnt_nxt = 2'd0;
          if (r_hold_full) begin
            w_shift_nxt = r_hold;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + 2'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = 2'd0;
      end
    endcase
  end

  // FSM state, counter and shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 2'd0;
      r_shift <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // One-entry hold register: a new symbol may overwrite it in the drain cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold      <= 4'd0;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= {w_bits_I, w_bits_Q};
      r_hold_full <= 1'b1;
    end else if (r_hold_full && w_drain) begin
      r_hold_full <= 1'b0;
    end
  end

  // Sticky overflow (a drop beats a simultaneous clear) and symbol counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_sym_count <= '0;
    end else begin
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
      if ((r_state == S_SHIFT) && (r_cnt == 2'd3)) begin
        r_sym_count <= r_sym_count + 1'b1;
      end
    end
  end

  // Serial outputs decoded from the shifter state; data_out is quiet when idle
  always_comb begin
    valid_out = (r_state == S_SHIFT);
    last_bit  = (r_state == S_SHIFT) && (r_cnt == 2'd3);
    data_out  = (r_state == S_SHIFT) && r_shift[2'd3 - r_cnt];
    ready     = w_ready;
    overflow  = r_overflow;
    sym_count = r_sym_count;
  end

endmodule

`default_nettype wire

// File: tb/tb_demapper_qam16.sv
//------------------------------------------------------------------------------
// Module      : tb_demapper_qam16
// Description : Self-checking bench for demapper_qam16 with a schedule-based
//               model of symbol acceptance and serial emission.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demapper_qam16;

  localparam int c_THR = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] data_I = '0;
  logic [15:0] data_Q = '0;
  logic        clr_ovf = 1'b0;

  logic        ready, data_out, valid_out, last_bit, overflow;
  logic [15:0] sym_count;
  logic        ready4, data_out4, valid_out4, last_bit4, overflow4;
  logic [3:0]  sym_count4;

  int checks = 0;
  int failures = 0;

  demapper_qam16 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .data_I(data_I), .data_Q(data_Q),
    .clr_ovf(clr_ovf), .ready(ready), .data_out(data_out), .valid_out(valid_out),
    .last_bit(last_bit), .overflow(overflow), .sym_count(sym_count)
  );

  demapper_qam16 #(.wid_cnt(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .data_I(data_I), .data_Q(data_Q),
    .clr_ovf(clr_ovf), .ready(ready4), .data_out(data_out4), .valid_out(valid_out4),
    .last_bit(last_bit4), .overflow(overflow4), .sym_count(sym_count4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Gray label of the nearest constellation level (-3,-1,+1,+3 units)
  function automatic logic [1:0] gray(input int x);
    if (x >= c_THR)       return 2'b10;  // +3
    else if (x >= 0)      return 2'b11;  // +1
    else if (x > -c_THR)  return 2'b01;  // -1
    else                  return 2'b00;  // -3
  endfunction

  // Model: each accepted symbol gets the edge at which it starts emitting
  int         cyc = 0;
  int         q_ts[$];
  logic [3:0] q_nib[$];
  int         m_cnt = 0;
  logic       m_ovf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ts.delete();
      q_nib.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
    end else begin
      int  k;
      bit  acc;
      int  ts;
      k   = cyc + 1;
      acc = (q_ts.size() == 0) || (q_ts[$] <= k);
      if (start && acc) begin
        ts = k + 1;
        if (q_ts.size() != 0 && q_ts[$] + 4 > ts) ts = q_ts[$] + 4;
        q_ts.push_back(ts);
        q_nib.push_back({gray(int'($signed(data_I))), gray(int'($signed(data_Q)))});
      end
      if (start && !acc) m_ovf = 1'b1;
      else if (clr_ovf)  m_ovf = 1'b0;
      cyc = k;
      while (q_ts.size() != 0 && q_ts[0] + 4 <= k) begin
        void'(q_ts.pop_front());
        void'(q_nib.pop_front());
        m_cnt++;
      end
    end
  end

  // Observed stream, used by the directed literal checks
  logic got[$];
  int   run = 0;
  int   max_run = 0;
  int   valid_seen = 0;

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    bit         ev;
    bit         eb;
    bit         el;
    int         idx;
    logic [3:0] n;
    bit         er;
    ev = 1'b0; eb = 1'b0; el = 1'b0;
    if (q_ts.size() != 0 && q_ts[0] <= cyc) begin
      idx = cyc - q_ts[0];
      n   = q_nib[0];
      ev  = 1'b1;
      eb  = n[3 - idx];
      el  = (idx == 3);
    end
    er = (q_ts.size() == 0) || (q_ts[$] <= cyc + 1);
    chk("valid_out", 32'(valid_out), 32'(ev));
    chk("last_bit", 32'(last_bit), 32'(el));
    if (ev) chk("data_out", 32'(data_out), 32'(eb));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sym_count", 32'(sym_count), 32'(m_cnt & 16'hFFFF));
    chk("sym_count4", 32'(sym_count4), 32'(m_cnt & 15));
    chk("ready", 32'(ready), 32'(er));
    if (valid_out) begin
      got.push_back(data_out);
      run++;
      valid_seen++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
  end

  task automatic sym(input int i, input int q);
    start  = 1'b1;
    data_I = 16'(i);
    data_Q = 16'(q);
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic got_nib(output logic [3:0] v);
    v = 4'd0;
    for (int i = 0; i < 4 && i < got.size(); i++) v[3-i] = got[i];
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  int lv[4] = '{-12288, -4096, 4096, 12288};
  logic [3:0] nib;

  initial begin
    // Pin the model's slicer with hand-computed labels
    chk("pin_1001", 32'({gray(12288), gray(-4096)}), 32'h9);
    chk("pin_1000", 32'({gray(8192), gray(-8192)}), 32'h8);
    chk("pin_1100", 32'({gray(0), gray(-32768)}), 32'hC);
    chk("pin_0111", 32'({gray(-4096), gray(4096)}), 32'h7);

    #1;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_valid", 32'(valid_out), 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    chk("post_rst_ready", 32'(ready), 32'd1);
    @(negedge clk);

    // Single symbol
    got.delete();
    sym(12288, -4096);
    repeat (7) @(negedge clk);
    got_nib(nib);
    chk("single_len", 32'(got.size()), 32'd4);
    chk("single_bits", 32'(nib), 32'h9);
    chk("single_count", 32'(sym_count), 32'd1);

    // Threshold and extreme values
    got.delete();
    sym(8192, -8192);
    repeat (7) @(negedge clk);
    got_nib(nib);
    chk("thr_bits", 32'(nib), 32'h8);
    got.delete();
    sym(0, -32768);
    repeat (7) @(negedge clk);
    got_nib(nib);
    chk("ext_bits", 32'(nib), 32'hC);
    chk("ext_ovf", 32'(overflow), 32'd0);

    // Back-to-back: 16 Gray combinations plus one more for the 4-bit wrap
    do_reset();
    got.delete();
    max_run = 0;
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++) begin
        sym(lv[a], lv[b]);
        repeat (3) @(negedge clk);
      end
    sym(12288, 12288);
    repeat (8) @(negedge clk);
    chk("b2b_len", 32'(got.size()), 32'd68);
    chk("b2b_run", 32'(max_run), 32'd68);
    chk("b2b_count", 32'(sym_count), 32'd17);
    chk("wrap_count4", 32'(sym_count4), 32'd1);
    chk("b2b_ovf", 32'(overflow), 32'd0);

    // Overrun, then clear racing a drop, then a plain clear
    got.delete();
    sym(4096, 4096);
    sym(-4096, -4096);
    sym(12288, 12288);
    chk("ovr_set", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    sym(12288, 12288);
    clr_ovf = 1'b0;
    chk("ovr_set_wins", 32'(overflow), 32'd1);
    repeat (8) @(negedge clk);
    chk("ovr_len", 32'(got.size()), 32'd8);
    clr_ovf = 1'b1;
    @(negedge clk);
    clr_ovf = 1'b0;
    chk("ovr_clear", 32'(overflow), 32'd0);

    // Reset during bit 2 with a second symbol held
    sym(12288, -12288);
    sym(-12288, 12288);
    @(negedge clk);
    chk("pre_rst_valid", 32'(valid_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(valid_out), 32'd0);
    chk("midrst_data", 32'(data_out), 32'd0);
    chk("midrst_last", 32'(last_bit), 32'd0);
    chk("midrst_count", 32'(sym_count), 32'd0);
    chk("midrst_ready", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    valid_seen = 0;
    repeat (10) @(negedge clk);
    chk("post_rst_quiet", 32'(valid_seen), 32'd0);
    got.delete();
    sym(-4096, 12288);
    repeat (7) @(negedge clk);
    got_nib(nib);
    chk("post_rst_bits", 32'(nib), 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
